// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch-side push bundle and decode-side head/stall bundle for the IF/ID queue.
interface if_id_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int LANES  = 2
);
    logic [LANES-1:0]        if_valid_i;
    logic [LANES*ADDR_W-1:0] if_pc_i;
    logic [LANES*INST_W-1:0] if_inst_i;
    logic                    if_ready_o;
    logic                    stall_i;
    logic [LANES-1:0]        id_valid_o;
    logic [LANES*ADDR_W-1:0] id_pc_o;
    logic [LANES*INST_W-1:0] id_inst_o;
    modport master (
        output if_valid_i, if_pc_i, if_inst_i, stall_i,
        input  if_ready_o, id_valid_o, id_pc_o, id_inst_o
    );
    modport slave (
        input  if_valid_i, if_pc_i, if_inst_i, stall_i,
        output if_ready_o, id_valid_o, id_pc_o, id_inst_o
    );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry circular IF/ID buffer moving up to LANES (pc, inst) pairs per cycle, flushable.
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 8,
    parameter int LANES  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    if_id_queue_if.slave               bus,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count, n_push, n_pop;
    logic [LANES-1:0]  id_valid;
    logic              ready;
    assign ready = count <= CW'(DEPTH - LANES);
    // only a contiguous run of valids from lane 0 is accepted
    assign n_push = (!ready || flush_i) ? '0 :
                    (LANES == 2 && &bus.if_valid_i) ? CW'(2) :
                    bus.if_valid_i[0] ? CW'(1) : '0;
    assign n_pop = bus.stall_i ? '0 : CW'($countones(id_valid));
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PW-1:0] p;
        assign p = rd_ptr + PW'(k);
        assign id_valid[k] = (count > CW'(k)) && !flush_i;
        assign bus.id_pc_o[k*ADDR_W +: ADDR_W] = id_valid[k] ? pc_mem[p] : '0;
        assign bus.id_inst_o[k*INST_W +: INST_W] = id_valid[k] ? inst_mem[p] : '0;
    end
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (CW'(k) < n_push) begin
                pc_mem[wr_ptr + PW'(k)]   <= bus.if_pc_i[k*ADDR_W +: ADDR_W];
                inst_mem[wr_ptr + PW'(k)] <= bus.if_inst_i[k*INST_W +: INST_W];
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_push[PW-1:0];
            rd_ptr <= rd_ptr + n_pop[PW-1:0];
            count  <= count + n_push - n_pop;
        end
    end
    assign bus.if_ready_o = ready;
    assign bus.id_valid_o = id_valid;
    assign count_o = count;
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: random and directed stimulus against a queue-based model of the IF/ID buffer.
module tb_if_id_queue;
    logic clk = 0, rst = 0, flush = 0;
    logic [3:0] count;
    if_id_queue_if #(.ADDR_W(32), .INST_W(32), .LANES(2)) bus();
    if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(8), .LANES(2)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .bus(bus), .count_o(count)
    );
    always #5 clk = ~clk;
    int vectors = 0, miscompares = 0;
    logic [63:0] q[$];
    logic [1:0]  ev;
    logic [63:0] epc, einst;
    int n, pops, pushes;
    task automatic cmp(string name, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask
    task automatic drive(logic [1:0] v, logic [31:0] pc0, logic [31:0] pc1, logic st, logic fl);
        bus.if_valid_i = v;
        bus.if_pc_i    = {pc1, pc0};
        bus.if_inst_i  = {pc1 ^ 32'h5a5a_a5a5, pc0 ^ 32'h5a5a_a5a5};
        bus.stall_i    = st;
        flush          = fl;
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // model: outputs are the first entries of a plain FIFO, updated from the inputs held over the edge
    always @(negedge clk) begin
        if (!rst) q.delete();
        n = q.size();
        ev = '0; epc = '0; einst = '0;
        for (int k = 0; k < 2; k++) begin
            if (n > k && !flush) begin
                ev[k] = 1'b1;
                epc[k*32 +: 32]   = q[k][63:32];
                einst[k*32 +: 32] = q[k][31:0];
            end
        end
        cmp("id_valid", 64'(bus.id_valid_o), 64'(ev));
        cmp("id_pc", bus.id_pc_o, epc);
        cmp("id_inst", bus.id_inst_o, einst);
        cmp("count", 64'(count), 64'(n));
        cmp("if_ready", 64'(bus.if_ready_o), 64'(n <= 6));
        if (rst && !flush) begin
            pops = bus.stall_i ? 0 : (n < 2 ? n : 2);
            pushes = (n > 6 || !bus.if_valid_i[0]) ? 0 : (bus.if_valid_i[1] ? 2 : 1);
            repeat (pops) void'(q.pop_front());
            for (int k = 0; k < pushes; k++)
                q.push_back({bus.if_pc_i[k*32 +: 32], bus.if_inst_i[k*32 +: 32]});
        end else q.delete();
    end
    initial begin
        drive(2'b00, 0, 0, 0, 0);
        #2;
        cmp("reset valid", 64'(bus.id_valid_o), 0);
        cmp("reset pc", bus.id_pc_o, 0);
        cmp("reset count", 64'(count), 0);
        cmp("reset ready", 64'(bus.if_ready_o), 1);
        @(posedge clk); #1;
        rst = 1;
        drive(2'b01, 32'h1c00_0000, 32'h0, 0, 0);
        tick;
        drive(2'b00, 0, 0, 1, 0);
        #1;
        cmp("single valid", 64'(bus.id_valid_o), 2'b01);
        cmp("single pc", bus.id_pc_o, 64'h1c00_0000);
        cmp("single count", 64'(count), 1);
        drive(2'b00, 0, 0, 0, 0);
        tick;
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 32'h100 + 16*i, 32'h104 + 16*i, 1, 0);
            tick;
            if (i == 2) begin
                cmp("fill count6", 64'(count), 6);
                cmp("fill ready6", 64'(bus.if_ready_o), 1);
            end
        end
        cmp("fill count8", 64'(count), 8);
        cmp("fill ready8", 64'(bus.if_ready_o), 0);
        drive(2'b11, 32'h200, 32'h204, 1, 0);
        tick;
        cmp("full count", 64'(count), 8);
        cmp("full head", bus.id_pc_o, 64'h0000_0104_0000_0100);
        drive(2'b00, 0, 0, 0, 0);
        repeat (4) tick;
        cmp("drained", 64'(count), 0);
        for (int i = 0; i < 10; i++) begin
            drive(2'b11, 8*i, 8*i + 4, 0, 0);
            tick;
            cmp("wrap count", 64'(count), 2);
            cmp("wrap head", bus.id_pc_o, {32'(8*i + 4), 32'(8*i)});
        end
        drive(2'b00, 0, 0, 0, 0);
        tick;
        drive(2'b11, 32'h10, 32'h14, 1, 0); tick;
        drive(2'b11, 32'h18, 32'h1c, 1, 0); tick;
        drive(2'b01, 32'h20, 32'h24, 1, 0); tick;
        cmp("pre-flush count", 64'(count), 5);
        drive(2'b11, 32'h30, 32'h34, 1, 1);
        #1;
        cmp("flush valid", 64'(bus.id_valid_o), 0);
        tick;
        drive(2'b00, 0, 0, 0, 0);
        #1;
        cmp("post-flush count", 64'(count), 0);
        cmp("post-flush valid", 64'(bus.id_valid_o), 0);
        cmp("post-flush pc", bus.id_pc_o, 0);
        drive(2'b10, 32'h40, 32'h44, 1, 0); tick;
        cmp("noncontig", 64'(count), 0);
        drive(2'b01, 32'h300, 32'h0, 1, 0); tick;
        cmp("partial count1", 64'(count), 1);
        drive(2'b11, 32'h304, 32'h308, 0, 0); tick;
        cmp("partial count2", 64'(count), 2);
        cmp("partial head", bus.id_pc_o, 64'h0000_0308_0000_0304);
        repeat (3000) begin
            drive(2'($urandom_range(0, 3)), $urandom, $urandom,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
            tick;
        end
        drive(2'b00, 0, 0, 0, 1); tick;
        repeat (3) begin
            drive(2'b11, $urandom, $urandom, 1, 0);
            tick;
        end
        cmp("pre-reset count", 64'(count), 6);
        #2 rst = 0;
        #1;
        cmp("async valid", 64'(bus.id_valid_o), 0);
        cmp("async pc", bus.id_pc_o, 0);
        cmp("async inst", bus.id_inst_o, 0);
        cmp("async count", 64'(count), 0);
        cmp("async ready", 64'(bus.if_ready_o), 1);
        @(posedge clk); #1;
        rst = 1;
        drive(2'b00, 0, 0, 0, 0);
        tick;
        cmp("after reset", 64'(count), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
